// File: rtl/sequence_controller_if.sv
// Handshake bundle between the VeriRISC sequencer and the core datapath.
// Master drives run control and decode inputs; slave returns the strobes.
interface sequence_controller_if #(
  parameter int op_width    = 3,
  parameter int phase_width = 3
);
  logic                   en;
  logic                   resume;
  logic [op_width-1:0]    opcode;
  logic                   zero;
  logic [phase_width-1:0] phase;
  logic                   halted;
  logic                   sel;
  logic                   rd;
  logic                   wr;
  logic                   ld_ir;
  logic                   ld_ac;
  logic                   ld_pc;
  logic                   inc_pc;
  logic                   data_e;
  logic                   halt;

  modport master (
    output en, resume, opcode, zero,
    input  phase, halted, sel, rd, wr,
    input  ld_ir, ld_ac, ld_pc, inc_pc,
    input  data_e, halt
  );

  modport slave (
    input  en, resume, opcode, zero,
    output phase, halted, sel, rd, wr,
    output ld_ir, ld_ac, ld_pc, inc_pc,
    output data_e, halt
  );
endinterface

// File: rtl/sequence_controller.sv
// VeriRISC instruction sequencer: 8-phase counter, HLT freeze and
// combinational decode of memory strobes and register load controls.
module sequence_controller #(
  parameter int op_width    = 3,
  parameter int phase_width = 3
) (
  input logic                  clk,
  input logic                  rst,
  sequence_controller_if.slave bus
);

  typedef enum logic [phase_width-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef enum logic [op_width-1:0] {
    I_HLT = 3'd0,
    I_SKZ = 3'd1,
    I_ADD = 3'd2,
    I_AND = 3'd3,
    I_XOR = 3'd4,
    I_LDA = 3'd5,
    I_STO = 3'd6,
    I_JMP = 3'd7
  } op_t;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_alu;

  logic sel, rd, wr, ld_ir, ld_ac;
  logic ld_pc, inc_pc, data_e, halt;

  assign is_hlt = (bus.opcode == I_HLT);
  assign is_skz = (bus.opcode == I_SKZ);
  assign is_sto = (bus.opcode == I_STO);
  assign is_jmp = (bus.opcode == I_JMP);
  assign is_alu = (bus.opcode == I_ADD) ||
                  (bus.opcode == I_AND) ||
                  (bus.opcode == I_XOR) ||
                  (bus.opcode == I_LDA);

  // Phase and halt state register; reset aborts any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: halt freezes everything until resume, else en advances.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      if (bus.resume && bus.en) begin
        halted_d = 1'b0;
        phase_d  = OP_FETCH;
      end
    end else if (bus.en) begin
      if (phase_q == OP_ADDR && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + phase_t'(1));
      end
    end
  end

  // Decode strobes from phase, opcode and zero; halted masks all but halt.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = !is_hlt;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = is_alu;
        end
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz && bus.zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
      endcase
    end
  end

  assign bus.phase  = phase_q;
  assign bus.halted = halted_q;
  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.wr     = wr;
  assign bus.ld_ir  = ld_ir;
  assign bus.ld_ac  = ld_ac;
  assign bus.ld_pc  = ld_pc;
  assign bus.inc_pc = inc_pc;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;

endmodule

// File: tb/tb_sequence_controller.sv
// Self-checking bench for sequence_controller: directed scenarios plus
// randomized run control checked every cycle against a behavioural model.
module tb_sequence_controller;

  logic clk;
  logic rst;

  sequence_controller_if bus ();

  sequence_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_phase  = 0;
  bit m_halted = 1'b0;
  bit m_valid  = 1'b0;

  // small memory + accumulator for the store/load round trip
  logic [7:0] mem [0:31];
  logic [7:0] ac;
  logic [4:0] addr;
  logic [7:0] dbus;

  assign dbus = bus.rd ? mem[addr] : (bus.data_e ? ac : 8'h00);

  always @(posedge clk) begin
    if (bus.wr) mem[addr] <= dbus;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}
  function automatic logic [8:0] expect_dec(int ph, bit h, int op, bit z);
    bit alu, sto, jmp, hlt, skz, run;
    logic [8:0] v;
    alu = (op >= 2) && (op <= 5);
    sto = (op == 6);
    jmp = (op == 7);
    hlt = (op == 0);
    skz = (op == 1);
    run = !h;
    v[8] = run && (ph <= 3);
    v[7] = run && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu));
    v[6] = run && (ph == 7) && sto;
    v[5] = run && (ph == 2 || ph == 3);
    v[4] = run && (ph == 7) && alu;
    v[3] = run && (ph >= 6) && jmp;
    v[2] = run && ((ph == 4 && !hlt) || (ph == 6 && skz && z));
    v[1] = run && (ph >= 6) && sto;
    v[0] = h || (ph == 4 && hlt);
    return v;
  endfunction

  function automatic logic [8:0] dut_dec();
    return {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
            bus.ld_pc, bus.inc_pc, bus.data_e, bus.halt};
  endfunction

  // Behavioural model: one phase per enabled clock, HLT freezes in ph4.
  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
      m_valid  <= 1'b1;
    end else if (m_halted) begin
      if (bus.resume && bus.en) begin
        m_halted <= 1'b0;
        m_phase  <= 5;
      end
    end else if (bus.en) begin
      if (m_phase == 4 && bus.opcode == 3'd0) m_halted <= 1'b1;
      else m_phase <= (m_phase + 1) % 8;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("phase", 32'(bus.phase), 32'(m_phase));
      chk("halted", 32'(bus.halted), 32'(m_halted));
      chk("decode", 32'(dut_dec()),
          32'(expect_dec(m_phase, m_halted, int'(bus.opcode), bus.zero)));
      chk("rd_and_data_e", 32'(bus.rd & bus.data_e), 32'd0);
      chk("wr_without_data_e", 32'(bus.wr & ~bus.data_e), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int p);
    int n = 0;
    while (m_phase != p && n < 20) begin
      tick();
      n++;
    end
    chk("run_to_reached", 32'(m_phase), 32'(p));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    ac          = 8'hA5;
    addr        = 5'h1F;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.resume  = 1'b0;
    bus.opcode  = 3'd5;
    bus.zero    = 1'b0;

    // 1: reset and a full phase sweep
    tick();
    tick();
    chk("reset_phase", 32'(bus.phase), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_dec", 32'(dut_dec()), 32'h100);
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_phase", 32'(bus.phase), 32'(i));
      if (i == 0) begin
        chk("ph0_sel", 32'(bus.sel), 32'd1);
        chk("ph0_rd", 32'(bus.rd), 32'd0);
      end
      if (i == 2) chk("ph2_ld_ir", 32'(bus.ld_ir), 32'd1);
      tick();
    end
    chk("wrap_phase", 32'(bus.phase), 32'd0);

    // 2: store A5 to 1F, load it back
    bus.opcode = 3'd6;
    run_to(7);
    chk("sto_wr", 32'(bus.wr), 32'd1);
    chk("sto_data_e", 32'(bus.data_e), 32'd1);
    chk("sto_rd", 32'(bus.rd), 32'd0);
    run_to(0);
    bus.opcode = 3'd5;
    run_to(5);
    chk("lda_rd", 32'(bus.rd), 32'd1);
    chk("lda_readback", 32'(dbus), 32'hA5);
    run_to(0);

    // 3: SKZ with zero set then clear
    bus.opcode = 3'd1;
    bus.zero   = 1'b1;
    run_to(4);
    chk("skz_z1_ph4_inc", 32'(bus.inc_pc), 32'd1);
    run_to(6);
    chk("skz_z1_ph6_inc", 32'(bus.inc_pc), 32'd1);
    run_to(0);
    bus.zero = 1'b0;
    run_to(4);
    chk("skz_z0_ph4_inc", 32'(bus.inc_pc), 32'd1);
    run_to(6);
    chk("skz_z0_ph6_inc", 32'(bus.inc_pc), 32'd0);
    run_to(0);

    // 4: HLT freezes, resume needs en
    bus.opcode = 3'd0;
    run_to(4);
    chk("hlt_ph4_halt", 32'(bus.halt), 32'd1);
    chk("hlt_ph4_inc", 32'(bus.inc_pc), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.en = 1'($urandom_range(0, 1));
      chk("halted_phase", 32'(bus.phase), 32'd4);
      chk("halted_flag", 32'(bus.halted), 32'd1);
      chk("halted_dec", 32'(dut_dec()), 32'h001);
      tick();
    end
    bus.en     = 1'b0;
    bus.resume = 1'b1;
    tick();
    chk("resume_no_en", 32'(bus.halted), 32'd1);
    bus.en = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("resume_phase", 32'(bus.phase), 32'd5);
    chk("resume_halted", 32'(bus.halted), 32'd0);

    // 5: stall at ph3, then stray resume while running
    bus.opcode = 3'd5;
    run_to(3);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_phase", 32'(bus.phase), 32'd3);
      chk("stall_dec", 32'(dut_dec()), 32'h1A0);
    end
    bus.en = 1'b1;
    tick();
    chk("unstall_phase", 32'(bus.phase), 32'd4);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("stray_resume_phase", 32'(bus.phase), 32'd5);
    chk("stray_resume_halted", 32'(bus.halted), 32'd0);

    // 6: reset mid-JMP and while halted
    bus.opcode = 3'd7;
    run_to(6);
    chk("jmp_ld_pc", 32'(bus.ld_pc), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_phase", 32'(bus.phase), 32'd0);
    chk("abort_ld_pc", 32'(bus.ld_pc), 32'd0);
    chk("abort_halted", 32'(bus.halted), 32'd0);
    rst        = 1'b0;
    bus.opcode = 3'd0;
    run_to(4);
    tick();
    chk("halt_before_rst", 32'(bus.halted), 32'd1);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_clears_halt", 32'(bus.halted), 32'd0);
    chk("rst_halt_phase", 32'(bus.phase), 32'd0);
    rst = 1'b0;

    // randomized run control
    for (int i = 0; i < 1500; i++) begin
      bus.en     = ($urandom_range(0, 9) != 0);
      bus.resume = ($urandom_range(0, 7) == 0);
      bus.opcode = 3'($urandom_range(0, 7));
      bus.zero   = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
